// File: rtl/ft245_sync_tx_if.sv
// Handshake and pin bundle between the sample source, the transmit engine and the FT232H.
// master = transmit engine side, slave = source / FT232H side.
interface ft245_sync_tx_if #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 32
);
  logic              enable_i;
  logic [1:0]        mode_i;
  logic [DATA_W-1:0] s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              ft_txe_i;
  logic [7:0]        ft_adbus_o;
  logic              ft_wr_o;
  logic              ft_rd_o;
  logic              ft_oe_o;
  logic              ft_siwu_o;
  logic              busy_o;
  logic [CNT_W-1:0]  byte_cnt_o;

  modport master (
    input  enable_i, mode_i, s_data_i, s_valid_i, ft_txe_i,
    output s_ready_o, ft_adbus_o, ft_wr_o, ft_rd_o, ft_oe_o, ft_siwu_o, busy_o, byte_cnt_o
  );

  modport slave (
    output enable_i, mode_i, s_data_i, s_valid_i, ft_txe_i,
    input  s_ready_o, ft_adbus_o, ft_wr_o, ft_rd_o, ft_oe_o, ft_siwu_o, busy_o, byte_cnt_o
  );
endinterface

// File: rtl/ft245_sync_tx.sv
// FT232H 245-synchronous-FIFO transmit engine: packs samples LSB-byte-first onto the bus,
// re-presenting any byte the FT232H refuses via TXE#.
module ft245_sync_tx #(
  parameter int                 DATA_W    = 12,
  parameter int                 CNT_W     = 32,
  parameter int                 BURST_ON  = 90,
  parameter int                 BURST_OFF = 90,
  parameter logic [DATA_W-1:0]  PAT_INIT  = '0
) (
  input logic clk_i,
  input logic rst_i,
  ft245_sync_tx_if.master bus
);
  localparam int BYTES     = (DATA_W + 7) / 8;
  localparam int IDX_W     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BURST_LEN = BURST_ON + BURST_OFF;
  localparam int BC_W      = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

  logic [7:0]         adbus_q;
  logic               wr_q;
  logic               busy_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BYTES*8-1:0] rest_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  pat_q;
  logic [BC_W-1:0]    burst_q;

  logic               accept;
  logic               last;
  logic               free;
  logic               src_rdy;
  logic               load;
  logic               busy_nxt;
  logic [DATA_W-1:0]  new_sample;
  logic [BYTES*8-1:0] pad;

  always_comb begin
    accept   = ~wr_q & ~bus.ft_txe_i;
    last     = (idx_q == IDX_W'(BYTES - 1));
    free     = ~busy_q | (accept & last);
    src_rdy  = 1'b0;
    case (bus.mode_i)
      2'd0:    src_rdy = bus.s_valid_i;
      2'd1:    src_rdy = 1'b1;
      2'd2:    src_rdy = (burst_q < BC_W'(BURST_ON));
      default: src_rdy = 1'b0;
    endcase
    load       = free & bus.enable_i & src_rdy;
    new_sample = (bus.mode_i == 2'd0) ? bus.s_data_i : pat_q;
    pad        = '0;
    pad[DATA_W-1:0] = new_sample;
    busy_nxt   = busy_q;
    if (load)
      busy_nxt = 1'b1;
    else if (accept & last)
      busy_nxt = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adbus_q <= '0;
      wr_q    <= 1'b1;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      rest_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= PAT_INIT;
      burst_q <= '0;
    end else begin
      burst_q <= (burst_q == BC_W'(BURST_LEN - 1)) ? '0 : burst_q + BC_W'(1);
      cnt_q   <= cnt_q + CNT_W'(accept);
      busy_q  <= busy_nxt;
      // WR# only asserts when the FT232H is ready and a byte will be on the bus.
      wr_q    <= ~(busy_nxt & ~bus.ft_txe_i);
      if (load) begin
        adbus_q <= pad[7:0];
        rest_q  <= pad >> 8;
        idx_q   <= '0;
        if (bus.mode_i != 2'd0)
          pat_q <= pat_q + DATA_W'(1);
      end else if (accept & ~last) begin
        adbus_q <= rest_q[7:0];
        rest_q  <= rest_q >> 8;
        idx_q   <= idx_q + IDX_W'(1);
      end
    end
  end

  assign bus.s_ready_o  = (bus.mode_i == 2'd0) & bus.enable_i & free & ~rst_i;
  assign bus.ft_adbus_o = adbus_q;
  assign bus.ft_wr_o    = wr_q;
  assign bus.ft_rd_o    = 1'b1;
  assign bus.ft_oe_o    = 1'b1;
  assign bus.ft_siwu_o  = 1'b1;
  assign bus.busy_o     = busy_q;
  assign bus.byte_cnt_o = cnt_q;
endmodule

// File: tb/tb_ft245_sync_tx.sv
// Directed bench: a 12-bit / 32-bit-counter engine and an 8-bit / 4-bit-counter burst engine.
module tb_ft245_sync_tx;
  logic clk = 1'b0;
  logic rst12, rst8;
  int n_checks = 0;
  int n_errors = 0;

  ft245_sync_tx_if #(.DATA_W(12), .CNT_W(32)) b12 ();
  ft245_sync_tx_if #(.DATA_W(8),  .CNT_W(4))  b8 ();

  ft245_sync_tx #(.DATA_W(12), .CNT_W(32)) u_dut12 (
    .clk_i (clk),
    .rst_i (rst12),
    .bus   (b12.master)
  );

  ft245_sync_tx #(.DATA_W(8), .CNT_W(4), .BURST_ON(4), .BURST_OFF(4)) u_dut8 (
    .clk_i (clk),
    .rst_i (rst8),
    .bus   (b8.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst12 = 1'b1;  rst8 = 1'b1;
    b12.enable_i = 1'b0; b12.mode_i = 2'd3; b12.s_data_i = '0; b12.s_valid_i = 1'b0; b12.ft_txe_i = 1'b1;
    b8.enable_i  = 1'b0; b8.mode_i  = 2'd3; b8.s_data_i  = '0; b8.s_valid_i  = 1'b0; b8.ft_txe_i  = 1'b1;
    repeat (2) tick();

    check("rst_wr",    64'(b12.ft_wr_o), 64'd1);
    check("rst_bus",   64'(b12.ft_adbus_o), 64'h0);
    check("rst_busy",  64'(b12.busy_o), 64'd0);
    check("rst_cnt",   64'(b12.byte_cnt_o), 64'd0);
    check("const_pins", 64'({b12.ft_rd_o, b12.ft_oe_o, b12.ft_siwu_o}), 64'b111);
    b12.mode_i = 2'd0; b12.enable_i = 1'b1; b12.s_valid_i = 1'b1;
    #1;
    check("rst_sready", 64'(b12.s_ready_o), 64'd0);

    // counter pattern, TXE# low: 00,00,01,00,02,00,...
    rst12 = 1'b0; b12.mode_i = 2'd1; b12.s_valid_i = 1'b0; b12.ft_txe_i = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("m1_bus", 64'(b12.ft_adbus_o), (k % 2 == 1) ? 64'((k - 1) / 2) : 64'h0);
      check("m1_wr",  64'(b12.ft_wr_o), 64'd0);
      check("m1_cnt", 64'(b12.byte_cnt_o), 64'(k - 1));
    end

    // switch to idle after byte0 of 0x005: remaining byte still goes out
    b12.mode_i = 2'd3;
    tick();
    check("m3_bus",  64'(b12.ft_adbus_o), 64'h00);
    check("m3_wr0",  64'(b12.ft_wr_o), 64'd0);
    check("m3_busy", 64'(b12.busy_o), 64'd1);
    tick();
    check("m3_wr1",   64'(b12.ft_wr_o), 64'd1);
    check("m3_idle",  64'(b12.busy_o), 64'd0);
    check("m3_cnt",   64'(b12.byte_cnt_o), 64'd12);
    tick();
    check("m3_hold_wr",  64'(b12.ft_wr_o), 64'd1);
    check("m3_hold_cnt", 64'(b12.byte_cnt_o), 64'd12);

    // stream 0xABC then 0x123 back-to-back
    b12.mode_i = 2'd0; b12.enable_i = 1'b1; b12.s_data_i = 12'hABC; b12.s_valid_i = 1'b1;
    #1;
    check("s_rdy_a", 64'(b12.s_ready_o), 64'd1);
    tick();
    check("s_bus_bc", 64'(b12.ft_adbus_o), 64'hBC);
    check("s_wr",     64'(b12.ft_wr_o), 64'd0);
    b12.s_data_i = 12'h123;
    #1;
    check("s_rdy_mid", 64'(b12.s_ready_o), 64'd0);
    tick();
    check("s_bus_0a", 64'(b12.ft_adbus_o), 64'h0A);
    check("s_rdy_b",  64'(b12.s_ready_o), 64'd1);
    tick();
    check("s_bus_23", 64'(b12.ft_adbus_o), 64'h23);
    b12.s_valid_i = 1'b0;
    tick();
    check("s_bus_01", 64'(b12.ft_adbus_o), 64'h01);
    check("s_wr_01",  64'(b12.ft_wr_o), 64'd0);
    tick();
    check("s_done_busy", 64'(b12.busy_o), 64'd0);
    check("s_done_wr",   64'(b12.ft_wr_o), 64'd1);
    check("s_done_cnt",  64'(b12.byte_cnt_o), 64'd16);

    // TXE# high for one cycle while 0A is on the bus
    b12.s_data_i = 12'hABC; b12.s_valid_i = 1'b1;
    tick();
    check("t_bus_bc", 64'(b12.ft_adbus_o), 64'hBC);
    b12.s_valid_i = 1'b0;
    tick();
    check("t_bus_0a", 64'(b12.ft_adbus_o), 64'h0A);
    check("t_cnt_a",  64'(b12.byte_cnt_o), 64'd17);
    b12.ft_txe_i = 1'b1;
    tick();
    check("t_wr_hi",  64'(b12.ft_wr_o), 64'd1);
    check("t_hold",   64'(b12.ft_adbus_o), 64'h0A);
    check("t_cnt_b",  64'(b12.byte_cnt_o), 64'd17);
    check("t_busy",   64'(b12.busy_o), 64'd1);
    b12.ft_txe_i = 1'b0;
    tick();
    check("t_wr_lo",  64'(b12.ft_wr_o), 64'd0);
    check("t_resend", 64'(b12.ft_adbus_o), 64'h0A);
    check("t_cnt_c",  64'(b12.byte_cnt_o), 64'd17);
    tick();
    check("t_cnt_end",  64'(b12.byte_cnt_o), 64'd18);
    check("t_busy_end", 64'(b12.busy_o), 64'd0);

    // pattern kept across modes, then reset mid-sample restarts it
    b12.mode_i = 2'd1;
    tick();
    check("p_kept", 64'(b12.ft_adbus_o), 64'h06);
    tick();
    check("p_b1",   64'(b12.ft_adbus_o), 64'h00);
    check("p_cnt",  64'(b12.byte_cnt_o), 64'd19);
    rst12 = 1'b1;
    tick();
    check("r_wr",   64'(b12.ft_wr_o), 64'd1);
    check("r_bus",  64'(b12.ft_adbus_o), 64'h00);
    check("r_busy", 64'(b12.busy_o), 64'd0);
    check("r_cnt",  64'(b12.byte_cnt_o), 64'd0);
    rst12 = 1'b0;
    tick();
    check("r_wr_lo",  64'(b12.ft_wr_o), 64'd0);
    check("r_busy_1", 64'(b12.busy_o), 64'd1);
    tick();
    tick();
    check("r_pat_restart", 64'(b12.ft_adbus_o), 64'h01);
    check("r_cnt2",        64'(b12.byte_cnt_o), 64'd2);

    // enable drop mid-sample drains the remaining byte
    b12.enable_i = 1'b0;
    tick();
    check("e_bus",  64'(b12.ft_adbus_o), 64'h00);
    check("e_busy", 64'(b12.busy_o), 64'd1);
    tick();
    check("e_idle", 64'(b12.busy_o), 64'd0);
    check("e_wr",   64'(b12.ft_wr_o), 64'd1);
    check("e_cnt",  64'(b12.byte_cnt_o), 64'd4);
    tick();
    check("e_cnt_hold", 64'(b12.byte_cnt_o), 64'd4);

    // 8-bit burst engine: 4 bytes per 8-cycle period, 4-bit counter wraps
    check("b_rst_wr",  64'(b8.ft_wr_o), 64'd1);
    check("b_rst_cnt", 64'(b8.byte_cnt_o), 64'd0);
    rst8 = 1'b0; b8.mode_i = 2'd2; b8.enable_i = 1'b1; b8.ft_txe_i = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      check("b_wr", 64'(b8.ft_wr_o), (((k - 1) % 8) < 4) ? 64'd0 : 64'd1);
      if (k <= 4)
        check("b_bus", 64'(b8.ft_adbus_o), 64'(k - 1));
      if (k % 8 == 1)
        check("b_cnt_period", 64'(b8.byte_cnt_o), 64'(((k - 1) / 2) % 16));
      if (k == 28)
        check("b_cnt_max", 64'(b8.byte_cnt_o), 64'd15);
      if (k == 29)
        check("b_cnt_wrap", 64'(b8.byte_cnt_o), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
